// File: rtl/entrada_stdin_pkg.sv
// Shared constants and helpers for the memory-mapped stdin peripheral:
// default register addresses, status bit layout and the read-select type.
package entrada_stdin_pkg;

  localparam logic [31:0] END_DADO_PAD   = 32'd60;
  localparam logic [31:0] END_STATUS_PAD = 32'd61;

  localparam int ST_NAOVAZIO = 0;
  localparam int ST_CHEIO    = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_CONT_LSB = 3;

  typedef enum logic [1:0] {
    SEL_NENHUM = 2'd0,
    SEL_DADO   = 2'd1,
    SEL_STATUS = 2'd2
  } sel_t;

  function automatic logic [31:0] empacota_status(
    input logic       nao_vazio,
    input logic       cheio,
    input logic       ovf,
    input logic [3:0] cont
  );
    logic [31:0] w_st;
    w_st                     = 32'd0;
    w_st[ST_NAOVAZIO]        = nao_vazio;
    w_st[ST_CHEIO]           = cheio;
    w_st[ST_OVF]             = ovf;
    w_st[ST_CONT_LSB +: 4]   = cont;
    return w_st;
  endfunction

endpackage

// File: rtl/entrada_stdin_debouncer.sv
// Push-button synchronizer and debouncer; emits a one-cycle pulse on the
// edge where a debounced rising transition is accepted.
module debouncer_botao
  import entrada_stdin_pkg::*;
#(
  parameter int DEB_CICLOS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  output logic pulso_sobe
);

  localparam int CW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;

  logic          r_meta;
  logic          r_b_s;
  logic          r_estavel;
  logic [CW-1:0] r_cnt;
  logic          w_difere;
  logic          w_fim;

  assign w_difere   = (r_b_s != r_estavel);
  assign w_fim      = w_difere && (r_cnt == CW'(DEB_CICLOS - 1));
  // The pulse coincides with the edge that updates the stable level.
  assign pulso_sobe = w_fim && r_b_s;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_b_s  <= 1'b0;
    end else begin
      r_meta <= botao;
      r_b_s  <= r_meta;
    end
  end

  // Debounce counter and stable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estavel <= 1'b0;
      r_cnt     <= '0;
    end else if (w_fim) begin
      r_estavel <= r_b_s;
      r_cnt     <= '0;
    end else if (w_difere) begin
      r_estavel <= r_estavel;
      r_cnt     <= r_cnt + CW'(1);
    end else begin
      r_estavel <= r_estavel;
      r_cnt     <= '0;
    end
  end

endmodule

// File: rtl/entrada_stdin.sv
// Memory-mapped input peripheral: debounced button presses capture the switch
// bank into a FIFO, read back through data (popping) and status addresses.
module entrada_stdin
  import entrada_stdin_pkg::*;
#(
  parameter int          DEB_CICLOS = 16,
  parameter int          PROF       = 4,
  parameter logic [31:0] END_DADO   = END_DADO_PAD,
  parameter logic [31:0] END_STATUS = END_STATUS_PAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        botao,
  input  logic [7:0]  chaves,
  input  logic [31:0] end_lei,
  input  logic        le,
  output logic [31:0] saida,
  output logic        tem_dado
);

  localparam int PW = $clog2(PROF);

  logic [7:0]  r_c_meta;
  logic [7:0]  r_c_s;
  logic [7:0]  r_mem [0:PROF-1];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_cont;
  logic          r_ovf;

  logic   w_pulso;
  logic   w_nao_vazio;
  logic   w_cheio;
  logic   w_pop;
  logic   w_aceita;
  logic   w_ovf_novo;
  logic   w_limpa_ovf;
  sel_t   w_sel;

  debouncer_botao #(
    .DEB_CICLOS (DEB_CICLOS)
  ) u_deb (
    .clk        (clk),
    .rst        (rst),
    .botao      (botao),
    .pulso_sobe (w_pulso)
  );

  // Two-flop synchronizer for the switch bank, aligned with the button path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_meta <= 8'd0;
      r_c_s    <= 8'd0;
    end else begin
      r_c_meta <= chaves;
      r_c_s    <= r_c_meta;
    end
  end

  // Address decode for the two mapped registers.
  always_comb begin
    w_sel = SEL_NENHUM;
    if (end_lei == END_DADO) begin
      w_sel = SEL_DADO;
    end else if (end_lei == END_STATUS) begin
      w_sel = SEL_STATUS;
    end else begin
      w_sel = SEL_NENHUM;
    end
  end

  assign w_nao_vazio = (r_cont != '0);
  assign w_cheio     = (r_cont == (PW+1)'(PROF));
  assign w_pop       = le && (w_sel == SEL_DADO) && w_nao_vazio;
  // A same-edge pop frees the slot a full FIFO needs.
  assign w_aceita    = w_pulso && (!w_cheio || w_pop);
  assign w_ovf_novo  = w_pulso && w_cheio && !w_pop;
  assign w_limpa_ovf = le && (w_sel == SEL_STATUS);
  assign tem_dado    = w_nao_vazio;

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_aceita) begin
      r_mem[r_tail] <= r_c_s;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cont <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_aceita) begin
        r_tail <= r_tail + PW'(1);
      end
      case ({w_aceita, w_pop})
        2'b10:   r_cont <= r_cont + (PW+1)'(1);
        2'b01:   r_cont <= r_cont - (PW+1)'(1);
        default: r_cont <= r_cont;
      endcase
      if (w_ovf_novo) begin
        r_ovf <= 1'b1;
      end else if (w_limpa_ovf) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  // Read mux onto the load path.
  always_comb begin
    saida = 32'd0;
    case (w_sel)
      SEL_DADO: begin
        if (w_nao_vazio) begin
          saida = {24'd0, r_mem[r_head]};
        end else begin
          saida = 32'd0;
        end
      end
      SEL_STATUS: saida = empacota_status(w_nao_vazio, w_cheio, r_ovf, 4'(r_cont));
      default:    saida = 32'd0;
    endcase
  end

endmodule
